lifo_pop_reader: RTL and testbench
==================================

Name: lifo_pop_reader

Overview:
- Read-side controller for the 8-bit LIFO stack. It issues pop strobes, captures the popped word and presents it on a valid/ready stream.
- Runs either a fixed-length burst or a drain-until-empty.
- It must be the sole pop source for the stack. It snoops the stack's push strobe so it can detect pops the stack ignores.

Parameters:
DATA_WIDTH, 8, width of stack words and out_data
CNT_WIDTH, 4, width of burst_len and pop_count (stack depth up to 15)

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a read operation; sampled only in IDLE
burst_len  input  CNT_WIDTH  words to pop; 0 = drain until empty; latched on start
stk_empty  input  1  stack empty flag (registered; lags top by one cycle)
stk_push  input  1  snoop of the stack's push strobe
stk_data  input  DATA_WIDTH  stack data_out; valid the cycle after an accepted pop
stk_pop  output  1  pop strobe to stack
out_data  output  DATA_WIDTH  popped word
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
drained  output  1  last operation ended because the stack was empty; held until next start
pop_count  output  CNT_WIDTH  words delivered in the current/last operation

Behaviour:
- Reset (async, immediate): state=IDLE; stk_pop=0, out_valid=0, out_data=0, busy=0, done=0, drained=0, pop_count=0. Reset mid-operation abandons the operation. Any word already popped is lost.
- States: IDLE, ISSUE, CAPTURE, HOLD, DONE.
- busy = 1 in ISSUE/CAPTURE/HOLD. done = 1 only in DONE.
- stk_pop is combinational: (state==ISSUE) && !stk_empty. It is never asserted in any other state.
- IDLE:
  - start=1 latches burst_len into len_r, clears pop_count and drained, then goes to ISSUE.
  - start while not in IDLE is ignored.
- ISSUE:
  - stk_empty=1: set drained=1, go to DONE.
  - stk_push=1 (stack drops a pop that coincides with a push): stay in ISSUE and retry next cycle.
  - Otherwise the pop is accepted: go to CAPTURE.
- CAPTURE (exactly one cycle):
  - out_data <= stk_data, out_valid <= 1, pop_count <= pop_count+1, go to HOLD.
- HOLD:
  - out_valid=1 and out_data stable while out_ready=0.
  - On out_valid && out_ready: out_valid <= 0.
  - Then if len_r!=0 && pop_count==len_r, go to DONE; else go to ISSUE.
- DONE (one cycle): done=1, then go to IDLE. pop_count and drained hold until the next start.
- Latency:
  - start edge to first stk_pop: 1 cycle.
  - Accepted pop to out_valid: 2 edges.
  - Peak throughput: one word per 3 cycles (ISSUE, CAPTURE, HOLD with out_ready=1).
- stk_empty timing: the minimum CAPTURE+HOLD gap guarantees stk_empty reflects the reader's own last pop before re-entering ISSUE.
  - A push in the cycle before ISSUE may still show stk_empty=1. The operation then ends drained; this is conservative and required behaviour.
- burst_len larger than the stack contents ends with drained=1 and pop_count equal to the actual number of words popped.
- pop_count never wraps: the maximum burst is 2^CNT_WIDTH-1.

Test Plan:
1. Push 0x11,0x22,0x33; start with burst_len=0 and out_ready=1 -> outputs 0x33,0x22,0x11; stk_pop pulses 3 times, 3 cycles apart; done pulses; pop_count=3; drained=1.
2. Push 0xA1..0xA5; start with burst_len=2 -> outputs 0xA5,0xA4; done; drained=0; pop_count=2; stack still holds 3 words (next pop returns 0xA3).
3. One word 0x5C; hold out_ready=0 for 5 cycles in HOLD -> out_valid=1 and out_data=0x5C stable; no stk_pop; after out_ready=1, a single handshake occurs.
4. Assert stk_push (data 0x77) in the ISSUE cycle over stack 0x10 -> pop dropped, ISSUE repeats, next output is 0x77, then 0x10.
5. Start with the stack empty -> no stk_pop; done 2 cycles after start; pop_count=0; drained=1.
6. Assert reset while in HOLD -> out_valid, busy and stk_pop go to 0 immediately; after release, a new start with burst_len=1 returns the current stack top.

Source files
------------

// File: rtl/lifo_pop_reader.sv
// lifo_pop_reader: read-side controller for a small LIFO stack.
//   This block issues pop strobes to the stack and captures each popped word.
//   Each captured word is presented on a valid/ready output stream.
//   An operation is either a fixed-length burst (burst_len != 0) or a
//   drain-until-empty (burst_len == 0).
//   The block must be the only pop source for the stack.
//   It snoops the stack's push strobe because the stack drops a pop that
//   coincides with a push. In that case the reader retries the pop.
//
// Ports:
//   clk, reset          clock (posedge) and asynchronous active-high reset
//   start, burst_len    begin an operation in IDLE; burst_len is latched on start
//   stk_empty           registered empty flag from the stack
//   stk_push            snoop of the stack's push strobe
//   stk_data            stack data_out, valid the cycle after an accepted pop
//   stk_pop             pop strobe to the stack (combinational)
//   out_data/out_valid/out_ready   output word stream
//   busy, done          operation in progress / one-cycle completion pulse
//   drained             last operation stopped on an empty stack
//   pop_count           words delivered in the current/last operation
module lifo_pop_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  input  logic                  stk_empty,
  input  logic                  stk_push,
  input  logic [DATA_WIDTH-1:0] stk_data,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  drained,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, HOLD, DONE} state_t;

  state_t               state, state_nx;
  logic [CNT_WIDTH-1:0] len_r;
  logic                 last_word;
  logic                 handshake;

  // A length of zero means drain until empty, so it never matches a count.
  assign last_word = (len_r != '0) && (pop_count == len_r);
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stk_pop  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = ISSUE;
      end
      ISSUE: begin
        busy    = 1'b1;
        stk_pop = !stk_empty;
        // The stack drops a pop that collides with a push, so stay here and retry.
        if (stk_empty)     state_nx = DONE;
        else if (!stk_push) state_nx = CAPTURE;
      end
      CAPTURE: begin
        busy     = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (handshake) state_nx = last_word ? DONE : ISSUE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r     <= '0;
      pop_count <= '0;
      drained   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_r     <= burst_len;
            pop_count <= '0;
            drained   <= 1'b0;
          end
        end
        ISSUE: begin
          if (stk_empty) drained <= 1'b1;
        end
        CAPTURE: begin
          // The stack presents the popped word in this cycle.
          out_data  <= stk_data;
          out_valid <= 1'b1;
          pop_count <= pop_count + 1'b1;
        end
        HOLD: begin
          if (handshake) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_pop_reader.sv
// Directed testbench for lifo_pop_reader with a behavioural LIFO stack model.
module tb_lifo_pop_reader;

  logic       clk = 1'b0;
  logic       reset, start, stk_empty, stk_push, stk_pop;
  logic       out_valid, out_ready, busy, done, drained;
  logic [3:0] burst_len, pop_count;
  logic [7:0] stk_data, out_data, push_data;
  logic       stk_rst;

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;

  logic [7:0] got[$];
  int         pop_cyc[$];
  int         done_cnt = 0;

  lifo_pop_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
    .stk_empty(stk_empty), .stk_push(stk_push), .stk_data(stk_data),
    .stk_pop(stk_pop), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .drained(drained),
    .pop_count(pop_count)
  );

  always #5 clk = ~clk;

  // Stack model: a push wins over a coincident pop.
  // The empty flag reflects the depth before the current edge.
  logic [7:0] mem [0:15];
  int         sp;
  always @(posedge clk) begin
    if (stk_rst) begin
      sp        <= 0;
      stk_empty <= 1'b1;
      stk_data  <= 8'h00;
    end else begin
      stk_empty <= (sp == 0);
      if (stk_push) begin
        mem[sp] <= push_data;
        sp      <= sp + 1;
      end else if (stk_pop && sp != 0) begin
        stk_data <= mem[sp-1];
        sp       <= sp - 1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back(out_data);
    if (stk_pop) pop_cyc.push_back(cyc);
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    stk_push = 1'b1; push_data = d; tick(); stk_push = 1'b0;
  endtask

  task automatic kick(input logic [3:0] len);
    burst_len = len; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stk_rst = 1'b1; start = 1'b0; burst_len = 4'd0;
    stk_push = 1'b0; push_data = 8'h00; out_ready = 1'b1;
    tick(); tick();
    vec++; if (stk_pop   !== 1'b0)  begin errs++; $display("FAIL reset_stk_pop got %b want 0", stk_pop); end
    vec++; if (out_valid !== 1'b0)  begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vec++; if (out_data  !== 8'h00) begin errs++; $display("FAIL reset_out_data got %h want 00", out_data); end
    vec++; if (busy      !== 1'b0)  begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (done      !== 1'b0)  begin errs++; $display("FAIL reset_done got %b want 0", done); end
    vec++; if (drained   !== 1'b0)  begin errs++; $display("FAIL reset_drained got %b want 0", drained); end
    vec++; if (pop_count !== 4'd0)  begin errs++; $display("FAIL reset_pop_count got %0d want 0", pop_count); end
    reset = 1'b0; stk_rst = 1'b0; tick();
  endtask

  task automatic test_drain();
    logic [7:0] exp [3] = '{8'h33, 8'h22, 8'h11};
    int b, pb, dc;
    bit ok;
    push_word(8'h11); push_word(8'h22); push_word(8'h33); tick();
    b = got.size(); pb = pop_cyc.size(); dc = done_cnt;
    out_ready = 1'b1;
    kick(4'd0);
    wait_done(60, ok); tick();
    vec++; if (!ok) begin errs++; $display("FAIL drain_timeout got no done want done"); end
    vec++; if (got.size() - b != 3) begin errs++; $display("FAIL drain_words got %0d want 3", got.size() - b); end
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (got.size() <= b + i || got[b+i] !== exp[i])
        begin errs++; $display("FAIL drain_word%0d got %h want %h", i, got[b+i], exp[i]); end
    end
    vec++; if (pop_cyc.size() - pb != 3) begin errs++; $display("FAIL drain_pops got %0d want 3", pop_cyc.size() - pb); end
    for (int i = 1; i < 3; i++) begin
      vec++;
      if (pop_cyc.size() <= pb + i || pop_cyc[pb+i] - pop_cyc[pb+i-1] != 3)
        begin errs++; $display("FAIL drain_pop_gap%0d got %0d want 3", i, pop_cyc[pb+i] - pop_cyc[pb+i-1]); end
    end
    vec++; if (done_cnt - dc != 1) begin errs++; $display("FAIL drain_done_pulses got %0d want 1", done_cnt - dc); end
    vec++; if (pop_count !== 4'd3) begin errs++; $display("FAIL drain_pop_count got %0d want 3", pop_count); end
    vec++; if (drained !== 1'b1) begin errs++; $display("FAIL drain_drained got %b want 1", drained); end
  endtask

  task automatic test_burst();
    int b;
    bit ok;
    for (int i = 0; i < 5; i++) push_word(8'hA1 + 8'(i));
    tick();
    b = got.size();
    kick(4'd2);
    wait_done(60, ok); tick();
    vec++; if (!ok) begin errs++; $display("FAIL burst_timeout got no done want done"); end
    vec++; if (got.size() - b != 2) begin errs++; $display("FAIL burst_words got %0d want 2", got.size() - b); end
    vec++; if (got.size() < b + 1 || got[b] !== 8'hA5) begin errs++; $display("FAIL burst_word0 got %h want a5", got[b]); end
    vec++; if (got.size() < b + 2 || got[b+1] !== 8'hA4) begin errs++; $display("FAIL burst_word1 got %h want a4", got[b+1]); end
    vec++; if (pop_count !== 4'd2) begin errs++; $display("FAIL burst_pop_count got %0d want 2", pop_count); end
    vec++; if (drained !== 1'b0) begin errs++; $display("FAIL burst_drained got %b want 0", drained); end
    // The remaining three words are still on the stack, top first.
    b = got.size();
    kick(4'd0);
    wait_done(60, ok); tick();
    vec++; if (!ok) begin errs++; $display("FAIL rest_timeout got no done want done"); end
    vec++; if (got.size() < b + 1 || got[b] !== 8'hA3) begin errs++; $display("FAIL rest_word0 got %h want a3", got[b]); end
    vec++; if (pop_count !== 4'd3) begin errs++; $display("FAIL rest_pop_count got %0d want 3", pop_count); end
    vec++; if (drained !== 1'b1) begin errs++; $display("FAIL rest_drained got %b want 1", drained); end
  endtask

  task automatic test_hold();
    int b, pb;
    bit ok;
    push_word(8'h5C); tick();
    out_ready = 1'b0;
    kick(4'd0);
    wait_valid(20, ok);
    vec++; if (!ok) begin errs++; $display("FAIL hold_timeout got no out_valid want out_valid"); end
    b = got.size(); pb = pop_cyc.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL hold_valid%0d got %b want 1", i, out_valid); end
      vec++; if (out_data !== 8'h5C) begin errs++; $display("FAIL hold_data%0d got %h want 5c", i, out_data); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(20, ok); tick();
    vec++; if (!ok) begin errs++; $display("FAIL hold_done_timeout got no done want done"); end
    vec++; if (pop_cyc.size() != pb) begin errs++; $display("FAIL hold_no_pop got %0d pops want 0", pop_cyc.size() - pb); end
    vec++; if (got.size() - b != 1) begin errs++; $display("FAIL hold_handshakes got %0d want 1", got.size() - b); end
    vec++; if (pop_count !== 4'd1) begin errs++; $display("FAIL hold_pop_count got %0d want 1", pop_count); end
  endtask

  task automatic test_push_retry();
    int b, pb;
    bit ok;
    push_word(8'h10); tick();
    out_ready = 1'b1;
    b = got.size(); pb = pop_cyc.size();
    burst_len = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Reader is in ISSUE now; collide a push with its pop.
    stk_push = 1'b1; push_data = 8'h77;
    tick();
    stk_push = 1'b0;
    wait_done(40, ok); tick();
    vec++; if (!ok) begin errs++; $display("FAIL retry_timeout got no done want done"); end
    vec++; if (pop_cyc.size() < pb + 2 || pop_cyc[pb+1] - pop_cyc[pb] != 1)
      begin errs++; $display("FAIL retry_repeat_gap got %0d want 1", pop_cyc[pb+1] - pop_cyc[pb]); end
    vec++; if (got.size() < b + 1 || got[b] !== 8'h77) begin errs++; $display("FAIL retry_word0 got %h want 77", got[b]); end
    vec++; if (got.size() < b + 2 || got[b+1] !== 8'h10) begin errs++; $display("FAIL retry_word1 got %h want 10", got[b+1]); end
    vec++; if (pop_count !== 4'd2) begin errs++; $display("FAIL retry_pop_count got %0d want 2", pop_count); end
    vec++; if (drained !== 1'b0) begin errs++; $display("FAIL retry_drained got %b want 0", drained); end
  endtask

  task automatic test_empty();
    int pb;
    tick();
    pb = pop_cyc.size();
    burst_len = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL empty_busy got %b want 1", busy); end
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL empty_done_early got %b want 0", done); end
    @(negedge clk);
    vec++; if (done !== 1'b1) begin errs++; $display("FAIL empty_done got %b want 1", done); end
    tick();
    vec++; if (pop_cyc.size() != pb) begin errs++; $display("FAIL empty_no_pop got %0d pops want 0", pop_cyc.size() - pb); end
    vec++; if (pop_count !== 4'd0) begin errs++; $display("FAIL empty_pop_count got %0d want 0", pop_count); end
    vec++; if (drained !== 1'b1) begin errs++; $display("FAIL empty_drained got %b want 1", drained); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL empty_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int b;
    bit ok;
    push_word(8'h61); push_word(8'h62); tick();
    out_ready = 1'b0;
    kick(4'd0);
    wait_valid(20, ok);
    vec++; if (!ok) begin errs++; $display("FAIL rmid_timeout got no out_valid want out_valid"); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got %b want 0", busy); end
    vec++; if (stk_pop !== 1'b0) begin errs++; $display("FAIL rmid_stk_pop got %b want 0", stk_pop); end
    vec++; if (pop_count !== 4'd0) begin errs++; $display("FAIL rmid_pop_count got %0d want 0", pop_count); end
    tick();
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    b = got.size();
    kick(4'd1);
    wait_done(40, ok); tick();
    vec++; if (!ok) begin errs++; $display("FAIL rmid_done_timeout got no done want done"); end
    vec++; if (got.size() - b != 1) begin errs++; $display("FAIL rmid_words got %0d want 1", got.size() - b); end
    vec++; if (got.size() < b + 1 || got[b] !== 8'h61) begin errs++; $display("FAIL rmid_word got %h want 61", got[b]); end
    vec++; if (pop_count !== 4'd1) begin errs++; $display("FAIL rmid_final_count got %0d want 1", pop_count); end
    vec++; if (drained !== 1'b0) begin errs++; $display("FAIL rmid_drained got %b want 0", drained); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_burst();
    test_hold();
    test_push_retry();
    test_empty();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

endmodule
